// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin scheduler for three ultrasonic rangers (left, front, right).
// One shared engine fires a trigger, times the echo pulse, applies a guard
// interval, then moves on to the next sensor.
module ultrasonic_scan_ctrl #(
  parameter int unsigned TRIG_CYC  = 500,
  parameter int unsigned RISE_TMO  = 50000,
  parameter int unsigned ECHO_MAX  = 1000000,
  parameter int unsigned GUARD_CYC = 3000000,
  parameter int unsigned THRESH    = 29000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  echo,
  output logic [2:0]  trig,
  output logic [19:0] left_time,
  output logic [19:0] front_time,
  output logic [19:0] right_time,
  output logic [2:0]  valid,
  output logic [2:0]  tmo,
  output logic [2:0]  obstacle,
  output logic        busy,
  output logic [1:0]  sel
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRIG  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MEAS  = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  localparam logic [21:0] TRIG_LAST  = 22'(TRIG_CYC - 1);
  localparam logic [21:0] RISE_LAST  = 22'(RISE_TMO - 1);
  localparam logic [21:0] ECHO_LIM   = 22'(ECHO_MAX);
  localparam logic [21:0] GUARD_LAST = 22'(GUARD_CYC - 1);
  localparam logic [19:0] ECHO_SAT   = 20'(ECHO_MAX);
  localparam logic [19:0] THRESH_W   = 20'(THRESH);

  logic [2:0]  state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  echo_s1_q, echo_s2_q;
  logic        echo_cur;
  logic        done;
  logic [19:0] done_val;
  logic        done_tmo;
  logic [19:0] left_q, front_q, right_q;
  logic [2:0]  valid_q, tmo_q, obstacle_q;

  // A measurement counts as an obstacle only if it is a real, unsaturated echo.
  function automatic logic is_obstacle(input logic [19:0] val, input logic sat);
    return !sat && (val < THRESH_W);
  endfunction

  // Two-flop synchronizer on the asynchronous echo pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s1_q <= 3'b000;
      echo_s2_q <= 3'b000;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
    end
  end

  assign echo_cur = echo_s2_q[sel_q];

  // Slot sequencing: next state, shared counter and sensor selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 22'd1;
    sel_d    = sel_q;
    done     = 1'b0;
    done_val = ECHO_SAT;
    done_tmo = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 22'd0;
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
          cnt_d   = 22'd0;
        end
      end
      S_WAIT: begin
        if (echo_cur) begin
          // The rise cycle itself is the first counted echo cycle.
          state_d = S_MEAS;
          cnt_d   = 22'd1;
        end else if (cnt_q == RISE_LAST) begin
          done     = 1'b1;
          done_tmo = 1'b1;
          state_d  = S_GUARD;
          cnt_d    = 22'd0;
        end
      end
      S_MEAS: begin
        if (!echo_cur) begin
          done     = 1'b1;
          done_val = cnt_q[19:0];
          state_d  = S_GUARD;
          cnt_d    = 22'd0;
        end else if (cnt_q == ECHO_LIM) begin
          done     = 1'b1;
          done_tmo = 1'b1;
          state_d  = S_GUARD;
          cnt_d    = 22'd0;
        end
      end
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = 22'd0;
          sel_d   = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          state_d = enable ? S_TRIG : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 22'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 22'd0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Result registers: width, status, obstacle and strobe all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q     <= 20'd0;
      front_q    <= 20'd0;
      right_q    <= 20'd0;
      valid_q    <= 3'b000;
      tmo_q      <= 3'b000;
      obstacle_q <= 3'b000;
    end else begin
      valid_q <= 3'b000;
      if (done) begin
        case (sel_q)
          2'd0: begin
            left_q        <= done_val;
            valid_q[0]    <= 1'b1;
            tmo_q[0]      <= done_tmo;
            obstacle_q[0] <= is_obstacle(done_val, done_tmo);
          end
          2'd1: begin
            front_q       <= done_val;
            valid_q[1]    <= 1'b1;
            tmo_q[1]      <= done_tmo;
            obstacle_q[1] <= is_obstacle(done_val, done_tmo);
          end
          2'd2: begin
            right_q       <= done_val;
            valid_q[2]    <= 1'b1;
            tmo_q[2]      <= done_tmo;
            obstacle_q[2] <= is_obstacle(done_val, done_tmo);
          end
          default: ;
        endcase
      end
    end
  end

  // Trigger is decoded from state so reset removes it immediately.
  assign trig       = (state_q == S_TRIG) ? (3'b001 << sel_q) : 3'b000;
  assign busy       = (state_q != S_IDLE);
  assign sel        = sel_q;
  assign left_time  = left_q;
  assign front_time = front_q;
  assign right_time = right_q;
  assign valid      = valid_q;
  assign tmo        = tmo_q;
  assign obstacle   = obstacle_q;

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Testbench for ultrasonic_scan_ctrl: drives echo pulses in response to the
// triggers and compares results against a slot-level reference model.
module tb_ultrasonic_scan_ctrl;

  localparam int TRIG_CYC  = 4;
  localparam int RISE_TMO  = 20;
  localparam int ECHO_MAX  = 100;
  localparam int GUARD_CYC = 8;
  localparam int THRESH    = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  echo;
  logic [2:0]  trig;
  logic [19:0] left_time, front_time, right_time;
  logic [2:0]  valid, tmo, obstacle;
  logic        busy;
  logic [1:0]  sel;

  int checks = 0;
  int errors = 0;
  int vpulses = 0;

  // Reference model: last published result per sensor and the expected owner.
  int exp_time [3];
  bit exp_tmo  [3];
  bit exp_obs  [3];
  int exp_sel;

  ultrasonic_scan_ctrl #(
    .TRIG_CYC(TRIG_CYC), .RISE_TMO(RISE_TMO), .ECHO_MAX(ECHO_MAX),
    .GUARD_CYC(GUARD_CYC), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
    .left_time(left_time), .front_time(front_time), .right_time(right_time),
    .valid(valid), .tmo(tmo), .obstacle(obstacle), .busy(busy), .sel(sel)
  );

  always #5 clk = ~clk;

  // Running count of all strobe pulses seen on any bit.
  always @(negedge clk) vpulses += $countones(valid);

  function automatic logic [2:0] vec3(input bit b0, input bit b1, input bit b2);
    return {b2, b1, b0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      exp_time[i] = 0;
      exp_tmo[i]  = 1'b0;
      exp_obs[i]  = 1'b0;
    end
    exp_sel = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (trig !== 3'b000 || valid !== 3'b000 || tmo !== 3'b000 || obstacle !== 3'b000 ||
        busy !== 1'b0 || sel !== 2'd0 || left_time !== 20'd0 || front_time !== 20'd0 ||
        right_time !== 20'd0) begin
      errors++;
      $display("FAIL %s: trig=%b valid=%b tmo=%b obs=%b busy=%b sel=%0d times=%0d/%0d/%0d, required all 0",
               tag, trig, valid, tmo, obstacle, busy, sel, left_time, front_time, right_time);
    end
  endtask

  // One complete slot for sensor exp_sel. has_echo=0 means the pin never rises;
  // otherwise the pin goes high d cycles after trig falls for w cycles.
  task automatic run_slot(input bit has_echo, input int d, input int w,
                          input bit stray, input bit drop_en);
    int s, k, j, hi, lim, base, k_exp, et;
    bit seen, etmo;
    logic [2:0] mask, pat;
    s    = exp_sel;
    mask = 3'b001 << s;
    base = vpulses;

    k = 0;
    while (trig[s] !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (trig[s] !== 1'b1) begin
      errors++;
      $display("FAIL trig_start[%0d]: trig=%b never rose, required bit %0d high", s, trig, s);
      return;
    end
    checks++;
    if (sel !== 2'(s)) begin
      errors++;
      $display("FAIL sel_at_trig: got %0d, required %0d", sel, s);
    end

    hi = 0;
    while (trig[s] === 1'b1 && hi < 500) begin
      checks++;
      if ((trig & ~mask) !== 3'b000) begin
        errors++;
        $display("FAIL trig_other[%0d]: trig=%b, required only bit %0d", s, trig, s);
      end
      @(negedge clk);
      hi++;
    end
    checks++;
    if (hi !== TRIG_CYC) begin
      errors++;
      $display("FAIL trig_width[%0d]: got %0d cycles, required %0d", s, hi, TRIG_CYC);
    end

    // Expected result from the measurement rules.
    if (!has_echo) begin
      et = ECHO_MAX; etmo = 1'b1; k_exp = RISE_TMO;
    end else if (w > ECHO_MAX) begin
      et = ECHO_MAX; etmo = 1'b1; k_exp = d + ECHO_MAX + 3;
    end else begin
      et = w; etmo = 1'b0; k_exp = d + w + 3;
    end

    k = 0;
    seen = 1'b0;
    lim = d + ECHO_MAX + 60;
    while (!seen && k < lim) begin
      pat = 3'b000;
      if (has_echo && k >= d && k < d + w) pat = mask;
      if (stray) pat = pat | (3'($urandom) & ~mask);
      echo = pat;
      if (drop_en && k == d + 4) enable = 1'b0;
      if (valid[s] === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL valid_timeout[%0d]: no strobe within %0d cycles", s, lim);
      echo = 3'b000;
      return;
    end

    exp_time[s] = et;
    exp_tmo[s]  = etmo;
    exp_obs[s]  = !etmo && (et < THRESH);

    checks++;
    if (k !== k_exp) begin
      errors++;
      $display("FAIL valid_latency[%0d]: got %0d cycles after trig fall, required %0d", s, k, k_exp);
    end
    checks++;
    if (valid !== mask) begin
      errors++;
      $display("FAIL valid_onehot[%0d]: got %b, required %b", s, valid, mask);
    end
    checks++;
    if (left_time !== 20'(exp_time[0]) || front_time !== 20'(exp_time[1]) ||
        right_time !== 20'(exp_time[2])) begin
      errors++;
      $display("FAIL times[%0d]: got %0d/%0d/%0d, required %0d/%0d/%0d", s,
               left_time, front_time, right_time, exp_time[0], exp_time[1], exp_time[2]);
    end
    checks++;
    if (tmo !== vec3(exp_tmo[0], exp_tmo[1], exp_tmo[2])) begin
      errors++;
      $display("FAIL tmo[%0d]: got %b, required %b", s, tmo, vec3(exp_tmo[0], exp_tmo[1], exp_tmo[2]));
    end
    checks++;
    if (obstacle !== vec3(exp_obs[0], exp_obs[1], exp_obs[2])) begin
      errors++;
      $display("FAIL obstacle[%0d]: got %b, required %b", s, obstacle, vec3(exp_obs[0], exp_obs[1], exp_obs[2]));
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_slot[%0d]: got %b, required 1", s, busy);
    end

    // Guard interval: strobe must not repeat, stray echoes must be ignored.
    j = 0;
    while (sel === 2'(s) && j < 100) begin
      @(negedge clk);
      j++;
      echo = (stray && j <= 3) ? 3'($urandom) : 3'b000;
      checks++;
      if (valid !== 3'b000) begin
        errors++;
        $display("FAIL valid_extra[%0d]: got %b at guard cycle %0d, required 000", s, valid, j);
      end
    end
    echo = 3'b000;
    exp_sel = (exp_sel + 1) % 3;
    checks++;
    if (j !== GUARD_CYC || sel !== 2'(exp_sel)) begin
      errors++;
      $display("FAIL guard[%0d]: sel=%0d after %0d cycles, required sel=%0d after %0d",
               s, sel, j, exp_sel, GUARD_CYC);
    end
    checks++;
    if (vpulses - base !== 1 ||
        left_time !== 20'(exp_time[0]) || front_time !== 20'(exp_time[1]) ||
        right_time !== 20'(exp_time[2])) begin
      errors++;
      $display("FAIL slot_end[%0d]: pulses=%0d times=%0d/%0d/%0d, required 1 pulse and %0d/%0d/%0d",
               s, vpulses - base, left_time, front_time, right_time,
               exp_time[0], exp_time[1], exp_time[2]);
    end
  endtask

  task automatic slot_rand(input bit stray);
    int r, d, w;
    r = $urandom_range(0, 9);
    d = $urandom_range(0, 12);
    if (r == 0)      run_slot(1'b0, d, 0, stray, 1'b0);
    else if (r == 1) run_slot(1'b1, d, $urandom_range(101, 130), stray, 1'b0);
    else begin
      w = $urandom_range(1, 60);
      run_slot(1'b1, d, w, stray, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    echo = 3'b000;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_idle");
  endtask

  task automatic test_first_scan();
    enable = 1'b1;
    run_slot(1'b1, 5, 50, 1'b0, 1'b0);   // left 50: no obstacle
    run_slot(1'b1, 3, 12, 1'b0, 1'b0);   // front 12: obstacle
    run_slot(1'b0, 0, 0, 1'b0, 1'b0);    // right silent: timeout, wraps to left
  endtask

  task automatic test_saturate();
    run_slot(1'b1, 2, 150, 1'b0, 1'b0);
    run_slot(1'b1, 4, 101, 1'b0, 1'b0);
    run_slot(1'b1, 1, 99, 1'b0, 1'b0);
  endtask

  task automatic test_stray();
    for (int i = 0; i < 4; i++) slot_rand(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) slot_rand(1'b0);
  endtask

  task automatic test_enable_drop();
    while (exp_sel != 1) slot_rand(1'b0);
    run_slot(1'b1, 3, 20, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (busy !== 1'b0 || trig !== 3'b000 || sel !== 2'd2) begin
        errors++;
        $display("FAIL enable_drop_idle: busy=%b trig=%b sel=%0d, required 0/000/2", busy, trig, sel);
      end
      @(negedge clk);
    end
    enable = 1'b1;
    run_slot(1'b1, 6, 33, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_trig();
    int k;
    k = 0;
    while (trig === 3'b000 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (trig === 3'b000) begin
      errors++;
      $display("FAIL reset_mid_trig_start: trig stayed 000, required a trigger");
      return;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    check_all_zero("reset_async_hold");
    rst = 1'b0;
    model_clear();
    run_slot(1'b1, 4, 25, 1'b0, 1'b0);
    run_slot(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_saturate();
    test_stray();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_trig();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
